// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
//   Shared types and constants for the minesweeper board logic.
//   - level_t       : board level as driven by the game-control FSM
//   - sched_state_t : states of the neighbour-count scheduler
//   - level_dim()   : board side length for a level (0 when no game)
//   Coordinates are COORD_W bits wide; board sides need one extra bit because
//   the hard board side (16) does not fit in a coordinate.
// -----------------------------------------------------------------------------
package game_pkg;

  localparam int MAX_DIM = 16;
  localparam int COORD_W = $clog2(MAX_DIM);
  localparam int DIM_W   = COORD_W + 1;

  localparam int DIM_EASY   = 8;
  localparam int DIM_MEDIUM = 10;
  localparam int DIM_HARD   = 16;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    EASY   = 2'd1,
    MEDIUM = 2'd2,
    HARD   = 2'd3
  } level_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    SINGLE = 2'd2,
    DRAIN  = 2'd3
  } sched_state_t;

  function automatic logic [DIM_W-1:0] level_dim(input level_t lvl);
    logic [DIM_W-1:0] dim;
    case (lvl)
      EASY:    dim = DIM_W'(DIM_EASY);
      MEDIUM:  dim = DIM_W'(DIM_MEDIUM);
      HARD:    dim = DIM_W'(DIM_HARD);
      default: dim = '0;
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/board_scan_counter.sv
// -----------------------------------------------------------------------------
// board_scan_counter
//   Row-major x/y walker over a dim x dim board. x advances first; when x
//   reaches dim-1 it wraps to 0 and y advances. The wrap points are explicit
//   compares against dim-1, so the counter works for any side up to MAX_DIM
//   without relying on natural overflow.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (x = y = 0)
//   load_zero  : restart at (0,0) next cycle; wins over en
//   en         : advance one cell
//   dim        : board side length (1..MAX_DIM)
//   x, y       : current cell
//   last       : current cell is (dim-1, dim-1)
// -----------------------------------------------------------------------------
module board_scan_counter
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_zero,
  input  logic               en,
  input  logic [DIM_W-1:0]   dim,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  logic [COORD_W-1:0] max_c;

  assign max_c = COORD_W'(dim - DIM_W'(1));
  assign last  = (x == max_c) && (y == max_c);

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge values of the others, regardless of statement order.
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (load_zero) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == max_c) begin
        x <= '0;
        if (y == max_c) y <= '0;
        else            y <= y + COORD_W'(1);
      end else begin
        x <= x + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/num_calc_sched.sv
// -----------------------------------------------------------------------------
// num_calc_sched
//   Decides which board cell the neighbour-mine-count pipeline evaluates each
//   cycle. Two requesters share the pipeline: a full-board rescan (scan_start)
//   and single-cell updates (cell_req/cell_ack handshake). Each job ends with a
//   PIPE_LAT-cycle drain and a one-cycle done pulse once its results are
//   written; done_scan tells which kind of job finished.
//   A one-entry pending buffer accepts a cell request while busy, and a
//   pending-scan flag remembers a rescan requested during SINGLE/DRAIN.
//   Any level change while busy aborts to IDLE and drops everything pending.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   level              : 0 none, 1 easy 8x8, 2 medium 10x10, 3 hard 16x16
//   scan_start         : one-cycle full-rescan request
//   cell_req           : single-cell request, held until cell_ack
//   cell_x, cell_y     : requested cell, stable while cell_req is high
//   cell_ack           : one-cycle pulse, request captured
//   calc_valid         : calc_x/calc_y issued to the datapath this cycle
//   calc_x, calc_y     : issued cell
//   calc_last          : final issue of the current job
//   busy               : scheduler not idle
//   done, done_scan    : job finished pulse; done_scan = 1 for a full scan
// -----------------------------------------------------------------------------
module num_calc_sched
  import game_pkg::*;
#(
  parameter int PIPE_LAT = 2   // must be >= 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         level,
  input  logic               scan_start,
  input  logic               cell_req,
  input  logic [COORD_W-1:0] cell_x,
  input  logic [COORD_W-1:0] cell_y,
  output logic               cell_ack,
  output logic               calc_valid,
  output logic [COORD_W-1:0] calc_x,
  output logic [COORD_W-1:0] calc_y,
  output logic               calc_last,
  output logic               busy,
  output logic               done,
  output logic               done_scan
);

  localparam logic [COORD_W-1:0] DRAIN_END = COORD_W'(PIPE_LAT - 1);

  sched_state_t       state;
  level_t             level_now;
  level_t             level_q;
  logic               level_changed;
  logic [DIM_W-1:0]   dim;

  logic               pend_full;
  logic               pend_scan;
  logic [COORD_W-1:0] pend_x;
  logic [COORD_W-1:0] pend_y;
  logic [COORD_W-1:0] single_x;
  logic [COORD_W-1:0] single_y;
  logic               job_scan;
  logic [COORD_W-1:0] drain_cnt;

  logic [COORD_W-1:0] scan_x;
  logic [COORD_W-1:0] scan_y;
  logic               scan_last;

  logic               req_take;
  logic               scan_go;
  logic               scan_restart;

  assign level_now     = level_t'(level);
  assign dim           = level_dim(level_now);
  assign level_changed = (level_now != level_q);

  // cell_ack is registered, so the requester still shows cell_req during the
  // ack cycle; ignoring it then keeps one request from being captured twice.
  assign req_take = cell_req && !cell_ack;

  assign scan_go      = (state == IDLE) && (level_now != NONE) &&
                        (scan_start || pend_scan);
  assign scan_restart = (state == SCAN) && scan_start && !level_changed;

  board_scan_counter u_scan (
    .clk       (clk),
    .rst       (rst),
    .load_zero (scan_go || scan_restart),
    .en        (state == SCAN),
    .dim       (dim),
    .x         (scan_x),
    .y         (scan_y),
    .last      (scan_last)
  );

  assign busy       = (state != IDLE);
  assign calc_valid = (state == SCAN) || (state == SINGLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    calc_x    = '0;
    calc_y    = '0;
    calc_last = 1'b0;
    case (state)
      SCAN: begin
        calc_x    = scan_x;
        calc_y    = scan_y;
        calc_last = scan_last;
      end
      SINGLE: begin
        calc_x    = single_x;
        calc_y    = single_y;
        calc_last = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the pending entry's coordinates are reset along with its valid
      // flag; it is a handful of flops, not a memory array.
      state     <= IDLE;
      level_q   <= NONE;
      pend_full <= 1'b0;
      pend_scan <= 1'b0;
      pend_x    <= '0;
      pend_y    <= '0;
      single_x  <= '0;
      single_y  <= '0;
      job_scan  <= 1'b0;
      drain_cnt <= '0;
      cell_ack  <= 1'b0;
      done      <= 1'b0;
      done_scan <= 1'b0;
    end else begin
      level_q   <= level_now;
      cell_ack  <= 1'b0;
      done      <= 1'b0;
      done_scan <= 1'b0;

      if ((state != IDLE) && level_changed) begin
        // Abort: the board under the running job no longer exists.
        state     <= IDLE;
        pend_full <= 1'b0;
        pend_scan <= 1'b0;
      end else begin
        if ((state != IDLE) && req_take && !pend_full) begin
          pend_full <= 1'b1;
          pend_x    <= cell_x;
          pend_y    <= cell_y;
          cell_ack  <= 1'b1;
        end

        if (((state == SINGLE) || (state == DRAIN)) && scan_start) begin
          pend_scan <= 1'b1;
        end

        case (state)
          IDLE: begin
            if (scan_go) begin
              state     <= SCAN;
              job_scan  <= 1'b1;
              pend_scan <= 1'b0;
            end else if (pend_full) begin
              state     <= SINGLE;
              job_scan  <= 1'b0;
              single_x  <= pend_x;
              single_y  <= pend_y;
              pend_full <= 1'b0;
            end else if ((level_now != NONE) && req_take) begin
              state    <= SINGLE;
              job_scan <= 1'b0;
              single_x <= cell_x;
              single_y <= cell_y;
              cell_ack <= 1'b1;
            end
          end

          SCAN: begin
            // A restart keeps SCAN; the counter reloads (0,0) on its own.
            if (!scan_start && scan_last) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end

          SINGLE: begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end

          DRAIN: begin
            if (drain_cnt == DRAIN_END) begin
              state     <= IDLE;
              done      <= 1'b1;
              done_scan <= job_scan;
            end else begin
              drain_cnt <= drain_cnt + COORD_W'(1);
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
